calyx_mem_d1_responder: RTL and testbench

- Responder (memory side) of the Calyx one-dimensional memory interface: addr0, write_data, write_en in; read_data, done out.
- Components drive this interface as initiators when they write a memory cell through external mem ports.
- Replaces the fixed single-cycle memory with a configurable write latency, so initiators' go/done handling is exercised under multi-cycle waits.
- Read path is combinational; writes are committed through a small FSM plus a latency counter.

---
 rtl/calyx_mem_pkg.sv | 20 ++
 rtl/calyx_mem_latency_ctr.sv | 36 +++
 rtl/calyx_mem_d1_responder.sv | 144 ++++++++++++++
 tb/tb_calyx_mem_d1_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calyx_mem_pkg.sv
// Shared definitions for the Calyx 1-D memory responder.
//   mem_resp_state_e : responder FSM states (IDLE, BUSY)
//   MAX_LATENCY      : largest supported write latency
//   CTR_W            : width of the latency counter, wide enough for 0..MAX_LATENCY
package calyx_mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_resp_state_e;

   localparam int MAX_LATENCY = 15;

   function automatic int ctr_width(input int max_lat);
      return $clog2(max_lat + 1);
   endfunction

   localparam int CTR_W = ctr_width(MAX_LATENCY);

endpackage

// File: rtl/calyx_mem_latency_ctr.sv
// Write-latency counter for the Calyx 1-D memory responder.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : force the count back to 0
//   start      : load 1 (the first BUSY cycle is already one cycle in)
//   enable     : increment the count
//   expire     : high while enabled and the count has reached LATENCY-1
module calyx_mem_latency_ctr
   import calyx_mem_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic start,
   input  logic enable,
   output logic expire
);

   localparam logic [CTR_W-1:0] EXPIRE_AT = CTR_W'(LATENCY - 1);

   logic [CTR_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (start)
         count <= CTR_W'(1);
      else if (enable)
         count <= count + 1'b1;
   end

   assign expire = enable && (count == EXPIRE_AT);

endmodule

// File: rtl/calyx_mem_d1_responder.sv
// Memory-side responder of the Calyx one-dimensional memory interface with a
// configurable write latency. Reads are combinational; writes commit LATENCY
// cycles after write_en is sampled, signalled by a one-cycle done pulse.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   addr0       : word address for both read and write
//   write_data  : data to store
//   write_en    : write request, only sampled while idle
//   read_data   : mem[addr0], or 0 when addr0 is out of range
//   done        : one-cycle pulse when a write commits
//   busy        : high while a write is pending
//   err         : sticky error flag (only when CALYX_MEM_RESP_ERR_EN is defined)
// Optional feature macro: CALYX_MEM_RESP_ERR_EN adds the err port and its logic.
// LATENCY must lie in 1..MAX_LATENCY; SIZE must not exceed 2**IDX_SIZE.
module calyx_mem_d1_responder
   import calyx_mem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4,
   parameter int LATENCY  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_SIZE-1:0] addr0,
   input  logic [WIDTH-1:0]    write_data,
   input  logic                write_en,
   output logic [WIDTH-1:0]    read_data,
   output logic                done,
   output logic                busy
`ifdef CALYX_MEM_RESP_ERR_EN
   ,
   output logic                err
`endif
);

   // One extra bit so SIZE == 2**IDX_SIZE is representable.
   localparam logic [IDX_SIZE:0] SIZE_L = (IDX_SIZE + 1)'(SIZE);
   localparam bit MULTI_CYCLE = (LATENCY > 1);

   logic [WIDTH-1:0] mem [SIZE];

   mem_resp_state_e     state;
   logic [IDX_SIZE-1:0] addr_q;
   logic [WIDTH-1:0]    data_q;

   logic addr_oob;
   logic accept;
   logic expire;
   logic finish;

   logic                mem_we;
   logic [IDX_SIZE-1:0] mem_waddr;
   logic [WIDTH-1:0]    mem_wdata;

   assign addr_oob = ({1'b0, addr0} >= SIZE_L);
   assign accept   = (state == IDLE) && write_en;
   assign finish   = (state == BUSY) && expire;

   calyx_mem_latency_ctr #(
      .LATENCY (LATENCY)
   ) u_lat_ctr (
      .clk    (clk),
      .reset  (reset),
      .clear  (finish),
      .start  (accept && MULTI_CYCLE),
      .enable (state == BUSY),
      .expire (expire)
   );

   // Single-cycle mode writes straight from the ports; otherwise from the
   // captured copy at expiry. Out-of-range addresses never touch the array,
   // and reset on the commit edge discards the pending write.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = data_q;
      if (!MULTI_CYCLE) begin
         mem_we    = accept && !addr_oob && !reset;
         mem_waddr = addr0;
         mem_wdata = write_data;
      end else begin
         mem_we = finish && ({1'b0, addr_q} < SIZE_L) && !reset;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // No forwarding of data_q: a read while busy sees the old contents.
   assign read_data = addr_oob ? '0 : mem[addr0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         busy   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (write_en) begin
                  if (!MULTI_CYCLE) begin
                     done <= 1'b1;
                  end else begin
                     addr_q <= addr0;
                     data_q <= write_data;
                     busy   <= 1'b1;
                     state  <= BUSY;
                  end
               end
            end
            BUSY: begin
               // write_en is ignored here; only expiry leaves BUSY.
               if (expire) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CALYX_MEM_RESP_ERR_EN
   // Offences: write while busy, accepted out-of-range write, out-of-range read.
   logic err_evt;
   assign err_evt = write_en ? ((state == BUSY) || addr_oob) : addr_oob;

   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if (err_evt)
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_calyx_mem_d1_responder.sv
module tb_calyx_mem_d1_responder;

   localparam int N = 4;

   // Instance configurations: 0:LAT1/16 1:LAT4/16 2:LAT3/16 3:LAT2/12
   function automatic int lat_of(input int g);
      case (g)
         0: return 1;
         1: return 4;
         2: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int size_of(input int g);
      return (g == 3) ? 12 : 16;
   endfunction

   function automatic logic [31:0] pat(input int i, input int a);
      return 32'hC000_0000 | (32'(i) << 8) | 32'(a);
   endfunction

   logic        clk = 1'b0;
   logic        rst [N];
   logic        we  [N];
   logic [3:0]  ad  [N];
   logic [31:0] wd  [N];
   logic [31:0] rd  [N];
   logic        dn  [N];
   logic        bs  [N];
`ifdef CALYX_MEM_RESP_ERR_EN
   logic        er  [N];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      calyx_mem_d1_responder #(
         .WIDTH    (32),
         .SIZE     (size_of(g)),
         .IDX_SIZE (4),
         .LATENCY  (lat_of(g))
      ) dut (
         .clk        (clk),
         .reset      (rst[g]),
         .addr0      (ad[g]),
         .write_data (wd[g]),
         .write_en   (we[g]),
         .read_data  (rd[g]),
         .done       (dn[g]),
         .busy       (bs[g])
`ifdef CALYX_MEM_RESP_ERR_EN
         ,
         .err        (er[g])
`endif
      );
   end

   // Behavioural model: a countdown of cycles left until commit per instance,
   // plus a shadow memory with known-value flags.
   int          rem    [N];
   logic [3:0]  pa     [N];
   logic [31:0] pd     [N];
   logic [31:0] mm     [N][16];
   bit          mv     [N][16];
   bit          m_done [N];
   bit          m_err  [N];
   bit          armed  [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; m_done[i] = 0; m_err[i] = 0; armed[i] = 0;
         for (int a = 0; a < 16; a++) mv[i][a] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst[i]) begin
            rem[i] = 0; m_done[i] = 0; m_err[i] = 0; armed[i] = 1;
         end else begin
            if (we[i] ? (rem[i] > 0 || int'(ad[i]) >= size_of(i)) : (int'(ad[i]) >= size_of(i)))
               m_err[i] = 1;
            m_done[i] = 0;
            if (rem[i] > 0) begin
               rem[i] = rem[i] - 1;
               if (rem[i] == 0) begin
                  m_done[i] = 1;
                  if (int'(pa[i]) < size_of(i)) begin mm[i][pa[i]] = pd[i]; mv[i][pa[i]] = 1; end
               end
            end else if (we[i]) begin
               if (lat_of(i) == 1) begin
                  m_done[i] = 1;
                  if (int'(ad[i]) < size_of(i)) begin mm[i][ad[i]] = wd[i]; mv[i][ad[i]] = 1; end
               end else begin
                  rem[i] = lat_of(i) - 1; pa[i] = ad[i]; pd[i] = wd[i];
               end
            end
         end
      end
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", nm, i, act, exp);
   endtask

   task automatic cmp_all();
      for (int i = 0; i < N; i++) begin
         if (armed[i]) begin
            chk("done", i, 32'(dn[i]), 32'(m_done[i]));
            chk("busy", i, 32'(bs[i]), 32'(rem[i] > 0));
            if (int'(ad[i]) >= size_of(i)) chk("read_oob", i, rd[i], 32'h0);
            else if (mv[i][ad[i]]) chk("read", i, rd[i], mm[i][ad[i]]);
`ifdef CALYX_MEM_RESP_ERR_EN
            chk("err", i, 32'(er[i]), 32'(m_err[i]));
`endif
         end
      end
   endtask

   task automatic half(); @(negedge clk); cmp_all(); endtask
   task automatic adv();  @(posedge clk); #1;        endtask
   task automatic cyc();  half(); adv();             endtask

   task automatic wr(input int i, input logic [3:0] a, input logic [31:0] d);
      bit got;
      got = 0;
      we[i] = 1; ad[i] = a; wd[i] = d;
      half(); adv();
      we[i] = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         half(); if (dn[i]) got = 1; adv();
      end
      if (!got) begin
         n_tot++;
         $display("FAIL done_timeout inst%0d: got no done, expected done within 20 cycles", i);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int np;
      for (int i = 0; i < N; i++) begin rst[i] = 1; we[i] = 0; ad[i] = 0; wd[i] = 0; end
      cyc(); cyc();
      for (int i = 0; i < N; i++) rst[i] = 0;
      half();
      for (int i = 0; i < N; i++) begin
         chk("reset_done", i, 32'(dn[i]), 32'h0);
         chk("reset_busy", i, 32'(bs[i]), 32'h0);
`ifdef CALYX_MEM_RESP_ERR_EN
         chk("reset_err", i, 32'(er[i]), 32'h0);
`endif
      end
      adv();

      // Preload every word so later reads have known contents.
      for (int i = 0; i < N; i++)
         for (int a = 0; a < size_of(i); a++) wr(i, 4'(a), pat(i, a));
      cyc();

      // LATENCY=1: single-cycle write.
      we[0] = 1; ad[0] = 3; wd[0] = 32'hA5;
      half(); chk("l1_c0_busy", 0, 32'(bs[0]), 32'h0); adv();
      we[0] = 0;
      half(); chk("l1_c1_done", 0, 32'(dn[0]), 32'h1); chk("l1_c1_read", 0, rd[0], 32'hA5);
      chk("l1_c1_busy", 0, 32'(bs[0]), 32'h0); adv();
      half(); chk("l1_c2_done", 0, 32'(dn[0]), 32'h0); chk("l1_c2_read", 0, rd[0], 32'hA5); adv();

      // LATENCY=4: busy window and old-value reads.
      we[1] = 1; ad[1] = 2; wd[1] = 32'h1234;
      cyc();
      we[1] = 0;
      for (int c = 1; c <= 3; c++) begin
         half(); chk("l4_busy", 1, 32'(bs[1]), 32'h1); chk("l4_nodone", 1, 32'(dn[1]), 32'h0);
         chk("l4_old", 1, rd[1], 32'hC000_0102); adv();
      end
      half(); chk("l4_done", 1, 32'(dn[1]), 32'h1); chk("l4_new", 1, rd[1], 32'h1234);
      chk("l4_idle", 1, 32'(bs[1]), 32'h0); adv();
      cyc();

      // LATENCY=4: write_en held for 10 cycles.
      np = 0;
      for (int c = 0; c < 10; c++) begin
         we[1] = 1; ad[1] = 5; wd[1] = 32'h500 + 32'(c);
         half();
         if (dn[1]) np++;
         if (c == 4 || c == 8) chk("hold_done", 1, 32'(dn[1]), 32'h1);
`ifdef CALYX_MEM_RESP_ERR_EN
         if (c == 1) chk("hold_err_c1", 1, 32'(er[1]), 32'h0);
         if (c == 2) chk("hold_err_c2", 1, 32'(er[1]), 32'h1);
`endif
         adv();
      end
      we[1] = 0;
      chk("hold_pulses", 1, 32'(np), 32'd2);
      repeat (4) cyc();
      half(); chk("hold_final", 1, rd[1], 32'h508); adv();

      // LATENCY=3: reset lands on the commit edge.
      we[2] = 1; ad[2] = 1; wd[2] = 32'hDEAD;
      cyc();
      we[2] = 0;
      half(); chk("rst_c1_busy", 2, 32'(bs[2]), 32'h1); adv();
      rst[2] = 1;
      half(); chk("rst_c2_busy", 2, 32'(bs[2]), 32'h1); adv();
      rst[2] = 0;
      half(); chk("rst_c3_busy", 2, 32'(bs[2]), 32'h0); chk("rst_c3_done", 2, 32'(dn[2]), 32'h0);
      chk("rst_keep", 2, rd[2], 32'hC000_0201); adv();
      for (int c = 0; c < 3; c++) begin
         half(); chk("rst_nodone", 2, 32'(dn[2]), 32'h0); adv();
      end

      // SIZE=12, LATENCY=2: out-of-range write.
      we[3] = 1; ad[3] = 13; wd[3] = 32'hFF;
      cyc();
      we[3] = 0;
      half(); chk("oob_busy", 3, 32'(bs[3]), 32'h1); adv();
      half(); chk("oob_done", 3, 32'(dn[3]), 32'h1); chk("oob_read", 3, rd[3], 32'h0);
`ifdef CALYX_MEM_RESP_ERR_EN
      chk("oob_err", 3, 32'(er[3]), 32'h1);
`endif
      adv();
      for (int a = 0; a < 12; a++) begin
         ad[3] = 4'(a);
         half(); chk("oob_unchanged", 3, rd[3], pat(3, a)); adv();
      end

      // LATENCY=2: back-to-back writes, second issued in the done cycle.
      we[3] = 1; ad[3] = 0; wd[3] = 32'hB0;
      cyc();
      we[3] = 0;
      half(); chk("b2b_c1", 3, 32'(dn[3]), 32'h0); adv();
      we[3] = 1; ad[3] = 1; wd[3] = 32'hB1;
      half(); chk("b2b_c2", 3, 32'(dn[3]), 32'h1); adv();
      we[3] = 0;
      half(); chk("b2b_c3", 3, 32'(dn[3]), 32'h0); adv();
      half(); chk("b2b_c4", 3, 32'(dn[3]), 32'h1); adv();
      ad[3] = 0; half(); chk("b2b_w0", 3, rd[3], 32'hB0); adv();
      ad[3] = 1; half(); chk("b2b_w1", 3, rd[3], 32'hB1); adv();

      // Final sweep of every address on every instance against the model.
      for (int i = 0; i < N; i++)
         for (int a = 0; a < 16; a++) begin ad[i] = 4'(a); cyc(); end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
